ldl_wrr_arb_v1: RTL

Weighted round-robin arbiter with packet lock, sharing one downstream port between up to REQ_WIDTH requesters. The grant is registered (valid/bin/hot) and is held for a whole packet, delimited by the granted requester's `last` flag. A requester keeps the port for up to `weight` consecutive packets before the pointer rotates. The block sits in front of a shared resource, such as a mux, FIFO write port or bus master, whose accept signal drives `ready`.

---
 rtl/ldl_wrr_arb_v1.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ldl_wrr_arb_v1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ldl_wrr_arb_v1 : weighted round-robin arbiter with per-packet grant lock    |
// | rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module ldl_wrr_arb_v1 #(
  parameter int BIN_WIDTH = 3,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH,
  parameter int WGT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_WIDTH-1:0]           req,
  input  logic [REQ_WIDTH-1:0]           last,
  input  logic [REQ_WIDTH*WGT_WIDTH-1:0] weight,
  input  logic                           ready,
  output logic                           valid,
  output logic [REQ_WIDTH-1:0]           hot,
  output logic [BIN_WIDTH-1:0]           bin,
  output logic                           lock
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] bin_q, bin_nxt;
  logic                 lock_q, lock_nxt;
  logic [WGT_WIDTH-1:0] pkt_cnt, pkt_cnt_nxt;
  logic [WGT_WIDTH-1:0] wgt_q, wgt_nxt;

  logic                 found;
  logic [BIN_WIDTH-1:0] pick;
  logic [BIN_WIDTH-1:0] idx;
  logic [WGT_WIDTH-1:0] pick_wgt;
  logic [WGT_WIDTH-1:0] pick_eff;
  logic                 acc;
  logic                 pkt_end;
  logic                 stay;

  // Search starts just after the current bin; the current bin is visited last.
  always_comb begin
    found = 1'b0;
    pick  = bin_q;
    idx   = '0;
    for (int i = 1; i <= REQ_WIDTH; i++) begin
      idx = bin_q + BIN_WIDTH'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_wgt = weight[int'(pick)*WGT_WIDTH +: WGT_WIDTH];
  assign pick_eff = (pick_wgt == '0) ? WGT_WIDTH'(1) : pick_wgt;

  assign acc     = (state == GRANT) && ready;
  assign pkt_end = acc && last[bin_q];
  assign stay    = (({1'b0, pkt_cnt} + (WGT_WIDTH+1)'(1)) < {1'b0, wgt_q}) && req[bin_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_q   <= '0;
      lock_q  <= 1'b0;
      pkt_cnt <= '0;
      wgt_q   <= WGT_WIDTH'(1);
    end else begin
      state   <= state_nxt;
      bin_q   <= bin_nxt;
      lock_q  <= lock_nxt;
      pkt_cnt <= pkt_cnt_nxt;
      wgt_q   <= wgt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bin_nxt     = bin_q;
    lock_nxt    = lock_q;
    pkt_cnt_nxt = pkt_cnt;
    wgt_nxt     = wgt_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = GRANT;
          bin_nxt     = pick;
          pkt_cnt_nxt = '0;
          wgt_nxt     = pick_eff;
          lock_nxt    = 1'b0;
        end
      end
      GRANT: begin
        if (acc && !pkt_end) begin
          lock_nxt = 1'b1;
        end else if (pkt_end) begin
          lock_nxt = 1'b0;
          if (stay) begin
            pkt_cnt_nxt = pkt_cnt + WGT_WIDTH'(1);
          end else if (found) begin
            bin_nxt     = pick;
            pkt_cnt_nxt = '0;
            wgt_nxt     = pick_eff;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign valid = (state == GRANT);
  assign bin   = bin_q;
  assign lock  = lock_q;

  generate
    for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_hot
      assign hot[g] = valid && (bin_q == BIN_WIDTH'(g));
    end
  endgenerate

endmodule
`default_nettype wire
